// File: rtl/dot_product_mac_if.sv
// Operand/result handshake bundle for dot_product_mac.
// The master side drives operands and consumes results; the slave side is the MAC.
interface dot_product_mac_if #(
    parameter int WIDTH = 11,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] l;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] O;
    logic             overflow;

    modport master (
        output in_valid, k, l, out_ready,
        input  in_ready, out_valid, O, overflow
    );

    modport slave (
        input  in_valid, k, l, out_ready,
        output in_ready, out_valid, O, overflow
    );
endinterface

// File: rtl/dot_product_mac.sv
// Streaming unsigned dot-product MAC: accumulates LEN products k*l, then holds the
// result until the consumer takes it. Wraps or saturates at ACC_W bits.
module dot_product_mac #(
    parameter int WIDTH = 11,
    parameter int LEN   = 4,
    parameter int ACC_W = 24,
    parameter int SAT   = 0
) (
    input logic           clock,
    input logic           reset,
    dot_product_mac_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [0:0]       ST_ACC   = 1'b0;
    localparam logic [0:0]       ST_HOLD  = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

    logic [0:0]       state_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] o_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sticky_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [2*WIDTH-1:0] prod_s;
    logic [ACC_W:0]     sum_s;
    logic [ACC_W-1:0]   next_acc_s;
    logic               carry_s;
    logic               accept_s;
    logic               last_s;

    // A carry pins the accumulator at all-ones in saturating builds; once there,
    // any further nonzero product carries again so it stays pinned for the vector.
    function automatic logic [ACC_W-1:0] sat_limit(input logic [ACC_W:0] sum);
        if ((SAT != 0) && sum[ACC_W]) begin
            sat_limit = ACC_MAX;
        end else begin
            sat_limit = sum[ACC_W-1:0];
        end
    endfunction

    // Full-precision product and one-bit-wider running sum for carry detection.
    always_comb begin
        prod_s     = {{WIDTH{1'b0}}, bus.k} * {{WIDTH{1'b0}}, bus.l};
        sum_s      = {1'b0, acc_r} + (ACC_W + 1)'(prod_s);
        carry_s    = sum_s[ACC_W];
        next_acc_s = sat_limit(sum_s);
        accept_s   = bus.in_valid && in_ready_r;
        last_s     = (cnt_r == LAST_CNT);
    end

    // Beat accumulation, result capture and ACC/HOLD sequencing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_ACC;
            acc_r       <= {ACC_W{1'b0}};
            o_r         <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sticky_r    <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        if (last_s) begin
                            o_r         <= next_acc_s;
                            ovf_r       <= sticky_r | carry_s;
                            acc_r       <= {ACC_W{1'b0}};
                            cnt_r       <= {CNT_W{1'b0}};
                            sticky_r    <= 1'b0;
                            state_r     <= ST_HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            acc_r    <= next_acc_s;
                            cnt_r    <= cnt_r + CNT_W'(1);
                            sticky_r <= sticky_r | carry_s;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_ACC;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.O         = o_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_dot_product_mac.sv
// Bench for dot_product_mac: three LEN=3 builds (wrap/24, sat/22, wrap/22) share one
// stimulus stream, plus a LEN=1 build; a cycle model feeds a result scoreboard.
module tb_dot_product_mac;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        g_valid, g_out_ready;
    logic [10:0] g_k, g_l;
    logic        d_valid, d_out_ready;
    logic [10:0] d_k, d_l;
    logic        mon_on;

    dot_product_mac_if #(.WIDTH(11), .ACC_W(24)) ifa ();
    dot_product_mac_if #(.WIDTH(11), .ACC_W(22)) ifb ();
    dot_product_mac_if #(.WIDTH(11), .ACC_W(22)) ifc ();
    dot_product_mac_if #(.WIDTH(11), .ACC_W(24)) ifd ();

    assign ifa.in_valid = g_valid;  assign ifa.k = g_k;  assign ifa.l = g_l;  assign ifa.out_ready = g_out_ready;
    assign ifb.in_valid = g_valid;  assign ifb.k = g_k;  assign ifb.l = g_l;  assign ifb.out_ready = g_out_ready;
    assign ifc.in_valid = g_valid;  assign ifc.k = g_k;  assign ifc.l = g_l;  assign ifc.out_ready = g_out_ready;
    assign ifd.in_valid = d_valid;  assign ifd.k = d_k;  assign ifd.l = d_l;  assign ifd.out_ready = d_out_ready;

    dot_product_mac #(.WIDTH(11), .LEN(3), .ACC_W(24), .SAT(0)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    dot_product_mac #(.WIDTH(11), .LEN(3), .ACC_W(22), .SAT(1)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));
    dot_product_mac #(.WIDTH(11), .LEN(3), .ACC_W(22), .SAT(0)) dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));
    dot_product_mac #(.WIDTH(11), .LEN(1), .ACC_W(24), .SAT(0)) dut_d (.clock(clock), .reset(reset), .bus(ifd.slave));

    typedef struct packed {
        logic [23:0] oa;
        logic [21:0] ob;
        logic [21:0] oc;
        logic        va;
        logic        vb;
        logic        vc;
    } res_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     aw   [3] = '{24, 22, 22};
    bit     sats [3] = '{1'b0, 1'b1, 1'b0};
    longint acc  [3];
    bit     stk  [3];
    int     g_cnt;
    bit     g_hold;
    bit     d_hold;
    res_t   gq[$];
    longint dq[$];
    res_t   r;
    longint p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint step(input longint a, input longint prod, input int w,
                                    input bit s, inout bit st);
        longint lim, sum;
        lim = longint'(1) << w;
        sum = a + prod;
        if (sum >= lim) begin
            st = 1'b1;
            return s ? lim - 1 : sum - lim;
        end
        return sum;
    endfunction

    // Compare outputs against the model, then advance the model with the inputs
    // that the coming rising edge will sample.
    always @(negedge clock) begin
        if (mon_on) begin
            chk("a_in_ready",  64'(ifa.in_ready),  64'(!g_hold));
            chk("b_in_ready",  64'(ifb.in_ready),  64'(!g_hold));
            chk("c_in_ready",  64'(ifc.in_ready),  64'(!g_hold));
            chk("a_out_valid", 64'(ifa.out_valid), 64'(g_hold));
            chk("b_out_valid", 64'(ifb.out_valid), 64'(g_hold));
            chk("c_out_valid", 64'(ifc.out_valid), 64'(g_hold));
            if (g_hold) begin
                chk("a_O",   64'(ifa.O),        64'(gq[0].oa));
                chk("b_O",   64'(ifb.O),        64'(gq[0].ob));
                chk("c_O",   64'(ifc.O),        64'(gq[0].oc));
                chk("a_ovf", 64'(ifa.overflow), 64'(gq[0].va));
                chk("b_ovf", 64'(ifb.overflow), 64'(gq[0].vb));
                chk("c_ovf", 64'(ifc.overflow), 64'(gq[0].vc));
            end
            chk("d_in_ready",  64'(ifd.in_ready),  64'(!d_hold));
            chk("d_out_valid", 64'(ifd.out_valid), 64'(d_hold));
            if (d_hold) begin
                chk("d_O",   64'(ifd.O),        64'(dq[0]));
                chk("d_ovf", 64'(ifd.overflow), 64'd0);
            end
        end
        if (reset) begin
            g_hold = 1'b0;
            d_hold = 1'b0;
            g_cnt  = 0;
            for (int i = 0; i < 3; i++) begin
                acc[i] = 0;
                stk[i] = 1'b0;
            end
            gq.delete();
            dq.delete();
        end else begin
            if (!g_hold) begin
                if (g_valid) begin
                    p = longint'(g_k) * longint'(g_l);
                    for (int i = 0; i < 3; i++) acc[i] = step(acc[i], p, aw[i], sats[i], stk[i]);
                    if (g_cnt == 2) begin
                        r.oa = 24'(acc[0]); r.ob = 22'(acc[1]); r.oc = 22'(acc[2]);
                        r.va = stk[0];      r.vb = stk[1];      r.vc = stk[2];
                        gq.push_back(r);
                        for (int i = 0; i < 3; i++) begin
                            acc[i] = 0;
                            stk[i] = 1'b0;
                        end
                        g_cnt  = 0;
                        g_hold = 1'b1;
                    end else begin
                        g_cnt++;
                    end
                end
            end else if (g_out_ready) begin
                void'(gq.pop_front());
                g_hold = 1'b0;
            end
            if (!d_hold) begin
                if (d_valid) begin
                    dq.push_back(longint'(d_k) * longint'(d_l));
                    d_hold = 1'b1;
                end
            end else if (d_out_ready) begin
                void'(dq.pop_front());
                d_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic g_beat(input logic [10:0] kk, input logic [10:0] ll);
        tick();
        g_valid = 1'b1;
        g_k     = kk;
        g_l     = ll;
    endtask

    task automatic g_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            g_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;  mon_on = 1'b0;
        g_valid = 1'b0; g_k = 11'd0; g_l = 11'd0; g_out_ready = 1'b0;
        d_valid = 1'b0; d_k = 11'd0; d_l = 11'd0; d_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_a_O",         64'(ifa.O),         64'd0);
        chk("rst_a_ovf",       64'(ifa.overflow),  64'd0);
        chk("rst_a_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_a_in_ready",  64'(ifa.in_ready),  64'd1);
        chk("rst_d_O",         64'(ifd.O),         64'd0);
        mon_on = 1'b1;

        // Back-to-back vector, consumer always ready.
        g_out_ready = 1'b1;
        g_beat(11'd3, 11'd5); g_beat(11'd2, 11'd9); g_beat(11'd8, 11'd3);
        g_idle(1);
        chk("t1_valid", 64'(ifa.out_valid), 64'd1);
        chk("t1_a_O",   64'(ifa.O),         64'd57);
        chk("t1_b_O",   64'(ifb.O),         64'd57);
        chk("t1_ovf",   64'(ifa.overflow),  64'd0);
        g_idle(1);
        chk("t1_drop",  64'(ifa.out_valid), 64'd0);

        // Consumer stalls five cycles while beats are offered and must be ignored.
        g_out_ready = 1'b0;
        g_beat(11'd3, 11'd5); g_beat(11'd2, 11'd9); g_beat(11'd8, 11'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            g_valid = 1'b1; g_k = 11'd7; g_l = 11'd7;
            chk("t2_hold_ready", 64'(ifa.in_ready), 64'd0);
            chk("t2_hold_O",     64'(ifa.O),        64'd57);
        end
        tick();
        g_valid = 1'b0; g_out_ready = 1'b1;
        chk("t2_still_valid", 64'(ifa.out_valid), 64'd1);
        tick();
        chk("t2_released", 64'(ifa.out_valid), 64'd0);
        g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1);
        g_idle(1);
        chk("t2_next_O", 64'(ifa.O), 64'd3);

        // Reset mid-vector, colliding with in_valid and out_ready.
        g_idle(1);
        g_beat(11'd3, 11'd5); g_beat(11'd2, 11'd9);
        tick();
        reset = 1'b1; g_valid = 1'b1; g_k = 11'd5; g_l = 11'd5;
        tick();
        reset = 1'b0; g_valid = 1'b0;
        chk("t3_rst_O",     64'(ifa.O),         64'd0);
        chk("t3_rst_valid", 64'(ifa.out_valid), 64'd0);
        g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1);
        g_idle(1);
        chk("t3_O", 64'(ifa.O), 64'd3);

        // Overflow: saturate vs wrap at 22 bits, no overflow at 24 bits.
        g_beat(11'd2047, 11'd2047); g_beat(11'd2047, 11'd2047); g_beat(11'd2047, 11'd2047);
        g_idle(1);
        chk("t4_sat_O",    64'(ifb.O),        64'd4194303);
        chk("t4_sat_ovf",  64'(ifb.overflow), 64'd1);
        chk("t4_wrap_O",   64'(ifc.O),        64'd4182019);
        chk("t4_wrap_ovf", 64'(ifc.overflow), 64'd1);
        chk("t4_wide_O",   64'(ifa.O),        64'd12570627);
        chk("t4_wide_ovf", 64'(ifa.overflow), 64'd0);
        g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1); g_beat(11'd1, 11'd1);
        g_idle(1);
        chk("t4_after_O",   64'(ifb.O),        64'd3);
        chk("t4_after_ovf", 64'(ifb.overflow), 64'd0);
        chk("t4_after_c",   64'(ifc.overflow), 64'd0);

        // Idle gaps between beats.
        g_beat(11'd3, 11'd5); g_idle(2);
        g_beat(11'd2, 11'd9); g_idle(2);
        g_beat(11'd8, 11'd3); g_idle(1);
        chk("t5_valid", 64'(ifa.out_valid), 64'd1);
        chk("t5_O",     64'(ifa.O),         64'd57);

        // Random valid/ready traffic checked by the scoreboard.
        for (int i = 0; i < 80; i++) begin
            tick();
            g_valid     = 1'($urandom_range(0, 1));
            g_k         = 11'($urandom_range(0, 2047));
            g_l         = 11'($urandom_range(0, 2047));
            g_out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        g_valid = 1'b0; g_out_ready = 1'b1;
        g_idle(3);

        // LEN=1: each accepted beat is a result one cycle later.
        d_out_ready = 1'b1;
        tick(); d_valid = 1'b1; d_k = 11'd4; d_l = 11'd4;
        tick(); d_valid = 1'b0;
        chk("t6_valid1", 64'(ifd.out_valid), 64'd1);
        chk("t6_O1",     64'(ifd.O),         64'd16);
        tick();
        chk("t6_back",   64'(ifd.out_valid), 64'd0);
        d_valid = 1'b1; d_k = 11'd5; d_l = 11'd5;
        tick(); d_valid = 1'b0;
        chk("t6_valid2", 64'(ifd.out_valid), 64'd1);
        chk("t6_O2",     64'(ifd.O),         64'd25);
        for (int i = 0; i < 40; i++) begin
            tick();
            d_valid     = 1'($urandom_range(0, 1));
            d_k         = 11'($urandom_range(0, 2047));
            d_l         = 11'($urandom_range(0, 2047));
            d_out_ready = ($urandom_range(0, 2) != 0);
        end
        tick();
        d_valid = 1'b0; d_out_ready = 1'b1;
        g_idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
